field_double_n: RTL
===================

// Module: field_double_n
// PURPOSE
//  Computes c = a * 2^n mod p (p = `F_Q) by n iterated modular doublings.
//  Inverse direction of field_halve: field_halve applied n times to c returns a.
//  Used to re-scale halved sums in the sumcheck prover/verifier datapath.
//  en/ready/ready_pulse handshake is identical to field_halve and field_multiplier.
// PARAMETERS
//  NSHIFT_BITS  6          width of shift count n (max n = 2^NSHIFT_BITS-1)
//  (field width `F_NBITS and modulus `F_Q come from the global field defines)
// PORTS
//  clk          in   1             clock, all state on rising edge
//  rstb         in   1             asynchronous active-low reset
//  en           in   1             start request, sampled only while ready=1
//  a            in   `F_NBITS      operand; a < `F_Q unless FIELD_DOUBLE_REDUCE_INPUT_EN
//  n            in   NSHIFT_BITS   number of doublings
//  ready_pulse  out  1             one-cycle strobe when c becomes valid
//  ready        out  1             idle / result valid
//  c            out  `F_NBITS      result a*2^n mod `F_Q
// BEHAVIOUR
//  Reset (rstb=0, async): ready=1, ready_pulse=0, c=0, acc=0, cnt=0, state IDLE.
//  States: IDLE, (REDUCE), SHIFT, DONE.
//  IDLE: ready=1. en=1 at edge -> acc<=a, cnt<=n, ready<=0, go REDUCE or SHIFT.
//  SHIFT: if cnt!=0: acc <= dbl(acc), cnt <= cnt-1; if cnt==0 -> DONE.
//   dbl(x): t = {x,1'b0} (F_NBITS+1 bits); result = (t >= `F_Q) ? t-`F_Q : t.
//   Compare/subtract in F_NBITS+1 bits; no overflow for x < `F_Q.
//  DONE (one cycle, folded into last SHIFT edge): c<=acc, ready<=1,
//   ready_pulse<=1, return IDLE. ready_pulse deasserts the following cycle.
//  Latency: en edge -> ready=1 after n+1 cycles (n=0: 1 cycle, c=a).
//  c holds last result until next completion; c not modified while busy.
//  en while ready=0: ignored, no queuing; a and n need only be stable at the
//   accepting edge.
//  en on the cycle ready_pulse=1: ready is high, request accepted normally.
//  rstb asserted mid-operation: operation discarded, reset values apply; no
//   ready_pulse generated for the aborted request.
//  a,n changes while busy: no effect.
// CONFIGURATION
//  FIELD_DOUBLE_REDUCE_INPUT_EN defined: extra REDUCE state after accept;
//   acc <= (acc >= `F_Q) ? acc-`F_Q : acc (a <= 2^`F_NBITS-1 < 2*`F_Q assumed
//   by field choice). Latency becomes n+2 cycles; any a in [0,2^`F_NBITS) legal.
//  Not defined: no REDUCE state; latency n+1; a >= `F_Q gives unspecified c
//   (bench checks only a < `F_Q).
// TESTING
//  1. Reset then idle: ready=1, ready_pulse=0, c=0 with no en.
//  2. a=1, n=3 -> c=8, ready rises 4 cycles after en edge (5 with REDUCE_EN),
//     ready_pulse high exactly 1 cycle.
//  3. a=`F_Q-1, n=1 -> c=`F_Q-2; a=5, n=0 -> c=5 after 1 cycle.
//  4. Round trip: 1000 random a (< `F_Q), n=1; feed c into field_halve ->
//     output equals a; also c equals field_multiplier(a, 2).
//  5. en pulsed at 2nd busy cycle with a=7 -> ignored, c from first request,
//     only one ready_pulse; en on ready_pulse cycle -> back-to-back accepted.
//  6. rstb low mid-SHIFT (a=3,n=10, after 4 cycles) -> immediate ready=1,
//     c=0, no ready_pulse; next request a=3,n=2 -> c=12.
//  7. REDUCE_EN only: a=`F_Q+4, n=1 -> c=8.

Source files
------------

// File: rtl/field_double_n.sv
// Modular doubling engine: c = a * 2^n mod `F_Q via n iterated doublings.
// Optional FIELD_DOUBLE_REDUCE_INPUT_EN adds an input-reduction cycle so any a < 2^`F_NBITS is legal.
`ifndef F_NBITS
`define F_NBITS 16
`endif
`ifndef F_Q
`define F_Q 65521
`endif

module field_double_n #(
    parameter int NSHIFT_BITS = 6
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   en,
    input  logic [`F_NBITS-1:0]    a,
    input  logic [NSHIFT_BITS-1:0] n,
    output logic                   ready_pulse,
    output logic                   ready,
    output logic [`F_NBITS-1:0]    c
);

    localparam int W = `F_NBITS;
    localparam logic [W:0] Q_EXT = (W+1)'(`F_Q);
    localparam logic [NSHIFT_BITS-1:0] CNT_ONE = NSHIFT_BITS'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDUCE,
        S_SHIFT
    } state_t;

    state_t                 r_state;
    logic [W-1:0]           r_acc;
    logic [NSHIFT_BITS-1:0] r_cnt;

    // One extra bit holds the doubled value so the compare never overflows for x < Q.
    function automatic logic [W-1:0] dbl(input logic [W-1:0] x);
        logic [W:0] t;
        t = {x, 1'b0};
        if (t >= Q_EXT)
            t = t - Q_EXT;
        return t[W-1:0];
    endfunction

`ifdef FIELD_DOUBLE_REDUCE_INPUT_EN
    function automatic logic [W-1:0] reduce_once(input logic [W-1:0] x);
        logic [W:0] t;
        t = {1'b0, x};
        if (t >= Q_EXT)
            t = t - Q_EXT;
        return t[W-1:0];
    endfunction
`endif

    // The DONE step is folded into the final SHIFT edge, where c is published.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            c           <= '0;
            ready       <= 1'b1;
            ready_pulse <= 1'b0;
        end else begin
            ready_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (en) begin
                        r_acc <= a;
                        r_cnt <= n;
                        ready <= 1'b0;
`ifdef FIELD_DOUBLE_REDUCE_INPUT_EN
                        r_state <= S_REDUCE;
`else
                        r_state <= S_SHIFT;
`endif
                    end
                end
                S_REDUCE: begin
`ifdef FIELD_DOUBLE_REDUCE_INPUT_EN
                    r_acc <= reduce_once(r_acc);
`endif
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (r_cnt != '0) begin
                        r_acc <= dbl(r_acc);
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        c           <= r_acc;
                        ready       <= 1'b1;
                        ready_pulse <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    ready   <= 1'b1;
                end
            endcase
        end
    end

endmodule
